fpu_cmd_sequencer: RTL and testbench
====================================

# fpu_cmd_sequencer

Command sequencer that sits between the SPI byte front end and the shared floating-point arithmetic unit of the SPI FPU. It owns the 4×32-bit float register file, decodes command bytes, assembles load payloads, issues operand pairs to the ALU over a valid/ready handshake, writes back results and streams register contents out byte-by-byte. Only one command is in flight at any time.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum cycles spent in WAIT before a timeout abort (used only with the macro).

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `cs_n`  in  1  SPI chip select, active-low; high aborts LOAD/READ.
- `cmd_valid`  in  1  command byte valid.
- `cmd_ready`  out  1  sequencer accepts a command.
- `cmd_data`  in  8  command: [7:6] op, [5:4] reg_a, [3:2] reg_b, [1:0] reg_dst.
- `in_valid`  in  1  payload byte valid.
- `in_ready`  out  1  payload byte accepted.
- `in_data`  in  8  payload byte.
- `out_valid`  out  1  readback byte valid.
- `out_ready`  in  1  consumer takes the readback byte.
- `out_data`  out  8  readback byte.
- `alu_op_valid`  out  1  operands presented to the ALU.
- `alu_op_ready`  in  1  ALU accepts the operands.
- `alu_op`  out  2  1 = ADD, 2 = SUB.
- `alu_a`, `alu_b`  out  32  operands, regs[reg_a] and regs[reg_b].
- `alu_result_valid`  in  1  result strobe, one cycle.
- `alu_result`  in  32  result word.
- `busy`  out  1  state != IDLE.
- `error`  out  1  sticky timeout flag.

## Operation
- Ops: 0 LOAD (4 bytes into regs[reg_dst]), 1 ADD, 2 SUB, 3 READ (4 bytes of regs[reg_a]).
- States: IDLE, LOAD, ISSUE, WAIT, READ.
- IDLE: `cmd_ready`=1. On `cmd_valid & cmd_ready`, latch the fields and go to LOAD, ISSUE or READ according to op. READ also snapshots regs[reg_a] into a 32-bit shadow in the same cycle.
- LOAD: `in_ready`=1. Each accepted byte is written at shadow byte index `cnt` (little-endian; byte 0 = bits 7:0), then `cnt` increments.
  - On the 4th byte, the assembled word is committed to regs[reg_dst] at that edge and the state returns to IDLE.
  - `cs_n`=1 before the 4th byte discards the shadow and returns to IDLE; the register is unchanged.
- ISSUE: `alu_op_valid`=1; `alu_a`, `alu_b` and `alu_op` are held stable until `alu_op_ready`. Go to WAIT on the handshake. `cs_n` is ignored.
- WAIT: on `alu_result_valid`, write `alu_result` to regs[reg_dst] and go to IDLE. `cs_n` is ignored.
- READ: `out_valid`=1 and `out_data` = shadow byte `cnt`. Advance on `out_ready`; after the 4th byte go to IDLE. `cs_n`=1 aborts to IDLE.
- `alu_result_valid` outside WAIT is ignored.
- `in_valid` outside LOAD is ignored (`in_ready`=0).
- reg_dst == reg_a or reg_b is legal: operands are sampled at issue, so the write-back does not disturb them.

## Timing
- Reset values:
  - state IDLE, `cnt`=0, all regs 0.
  - `cmd_ready`=1; `in_ready`, `out_valid`, `alu_op_valid`, `busy` and `error` = 0.
  - `out_data`, `alu_a`, `alu_b` = 0; `alu_op`=0.
- Reset mid-operation returns to IDLE at the next edge and clears the register file. A late `alu_result_valid` after reset is ignored.
- Command accept → `busy`=1 and the first LOAD/ISSUE/READ cycle on the next edge.
- LOAD commit → regs visible and `cmd_ready`=1 on the next cycle.
- ADD/SUB latency = 1 (ISSUE) + ALU handshake wait + ALU latency + 1 (write-back edge).
- READ throughput: 1 byte per cycle with `out_ready` held high; `out_data` is stable while `out_valid & !out_ready`.
- Abort via `cs_n` takes effect at the edge where `cs_n` is sampled high; no byte is transferred on that edge.

## Configuration
- `FPU_SEQ_TIMEOUT_EN` defined:
  - A WAIT cycle counter starts at the issue handshake.
  - If it reaches `TIMEOUT` without `alu_result_valid`, set `error`=1 (sticky until reset), leave regs unchanged and return to IDLE.
- Not defined:
  - No counter; WAIT waits indefinitely.
  - `error` is tied to 0.

## Test plan
- LOAD bytes 00,00,80,3F with cmd 0x02 (LOAD dst=2), then READ cmd 0xE0 (READ a=2) → `out_data` sequence 00,00,80,3F; `busy` drops after the 4th byte.
- regs0=0x3F800000, regs1=0x40000000; cmd 0x46 → `alu_a`=0x3F800000, `alu_b`=0x40000000, `alu_op`=1. ALU model returns 0x40400000 after 3 cycles → READ of reg 2 yields 00,00,40,40.
- LOAD dst=1 with 2 bytes, then `cs_n`=1 → IDLE next cycle, `cmd_ready`=1, regs1 unchanged.
- READ with `out_ready` toggled 1,0,0,1,1,0,1 → exactly 4 bytes transferred, `out_data` stable during stalls.
- ALU never responds:
  - With `FPU_SEQ_TIMEOUT_EN` → `error`=1 exactly 15 cycles after the issue handshake, back to IDLE.
  - Without the macro → `busy` stays 1.
- Reset asserted in WAIT, then `alu_result_valid` pulses → IDLE, all regs 0, result discarded.

Source files
------------

// File: rtl/fpu_cmd_sequencer.sv
// Command sequencer for the SPI FPU: register file, command decode, load/readback, ALU issue.
// Optional WAIT timeout abort enabled by defining FPU_SEQ_TIMEOUT_EN.
module fpu_cmd_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        alu_op_valid,
  input  logic        alu_op_ready,
  output logic [1:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        alu_result_valid,
  input  logic [31:0] alu_result,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_READ} state_t;

  state_t            state, state_nx;
  logic [1:0]        cnt, cnt_nx;
  logic [31:0]       shadow, shadow_nx;
  logic [3:0][31:0]  regs;
  logic [1:0]        op_q, ra_q, rb_q, rd_q;
  logic              wr_en;
  logic [31:0]       wr_data;
  logic              timeout_hit;

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt;
  logic          err_q;

  // Counts WAIT cycles; value 1 on the first WAIT cycle after the issue handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_ISSUE && alu_op_ready) wcnt <= TW'(1);
      else if (state == S_WAIT)             wcnt <= wcnt + TW'(1);
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign error = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      shadow <= '0;
      regs   <= '0;
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      rd_q   <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      shadow <= shadow_nx;
      if (state == S_IDLE && cmd_valid) {op_q, ra_q, rb_q, rd_q} <= cmd_data;
      if (wr_en) regs[rd_q] <= wr_data;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    shadow_nx   = shadow;
    wr_en       = 1'b0;
    wr_data     = alu_result;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: if (cmd_valid) begin
        cnt_nx = '0;
        case (cmd_data[7:6])
          2'd0:    state_nx = S_LOAD;
          2'd3: begin
            state_nx  = S_READ;
            shadow_nx = regs[cmd_data[5:4]];
          end
          default: state_nx = S_ISSUE;
        endcase
      end
      S_LOAD: begin
        if (cs_n) begin
          state_nx  = S_IDLE;
          cnt_nx    = '0;
          shadow_nx = '0;
        end else if (in_valid) begin
          shadow_nx[{cnt, 3'b000} +: 8] = in_data;
          if (cnt == 2'd3) begin
            wr_en    = 1'b1;
            wr_data  = {in_data, shadow[23:0]};
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 2'd1;
          end
        end
      end
      S_ISSUE: if (alu_op_ready) state_nx = S_WAIT;
      S_WAIT: begin
        if (alu_result_valid) begin
          wr_en    = 1'b1;
          state_nx = S_IDLE;
        end
`ifdef FPU_SEQ_TIMEOUT_EN
        else if (wcnt == TW'(TIMEOUT)) begin
          timeout_hit = 1'b1;
          state_nx    = S_IDLE;
        end
`endif
      end
      S_READ: begin
        if (cs_n) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (out_ready) begin
          if (cnt == 2'd3) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 2'd1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operands read straight from the register file: nothing can write it while in ISSUE.
  assign cmd_ready    = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign in_ready     = (state == S_LOAD) && !cs_n;
  assign out_valid    = (state == S_READ) && !cs_n;
  assign out_data     = (state == S_READ) ? shadow[{cnt, 3'b000} +: 8] : 8'h00;
  assign alu_op_valid = (state == S_ISSUE);
  assign alu_op       = (state == S_ISSUE) ? op_q : 2'd0;
  assign alu_a        = (state == S_ISSUE) ? regs[ra_q] : 32'h0;
  assign alu_b        = (state == S_ISSUE) ? regs[rb_q] : 32'h0;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Randomized bench for fpu_cmd_sequencer against a register-file reference model.
module tb_fpu_cmd_sequencer;
  logic        clock, reset, cs_n;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_data;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        alu_op_valid, alu_op_ready;
  logic [1:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        alu_result_valid;
  logic [31:0] alu_result;
  logic        busy, error;

  int          nchk = 0, nerr = 0;
  logic [31:0] mreg [4];
  bit          pat [7];

  fpu_cmd_sequencer #(.TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .cs_n(cs_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .alu_op_valid(alu_op_valid), .alu_op_ready(alu_op_ready), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_result_valid(alu_result_valid), .alu_result(alu_result),
    .busy(busy), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return 8'((w >> (8 * i)) & 32'hFF);
  endfunction

  // Presents one command with junk on the ignored payload/result inputs.
  task automatic send_cmd(input logic [7:0] c);
    int cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid        = 1'b1;
    cmd_data         = c;
    in_valid         = 1'($urandom % 2);
    in_data          = 8'($urandom);
    alu_result_valid = 1'($urandom % 2);
    alu_result       = $urandom;
    @(negedge clock);
    cmd_valid        = 1'b0;
    in_valid         = 1'b0;
    alu_result_valid = 1'b0;
  endtask

  task automatic load(input logic [1:0] d, input logic [31:0] w, input int nbytes);
    send_cmd({2'd0, 4'd0, d});
    for (int i = 0; i < nbytes; i++) begin
      while ($urandom % 3 == 0) @(negedge clock);
      chk("load_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = byte_of(w, i);
      @(negedge clock);
      in_valid = 1'b0;
    end
    if (nbytes < 4) begin
      cs_n     = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clock);
      cs_n     = 1'b0;
      in_valid = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    end else begin
      mreg[d] = w;
      chk("load_busy", 32'(busy), 32'd0);
      chk("load_cmd_ready", 32'(cmd_ready), 32'd1);
    end
  endtask

  task automatic read(input logic [1:0] a, input bit use_pat);
    int idx = 0, p = 0, cyc = 0;
    bit r;
    logic [31:0] exp_w;
    send_cmd({2'd3, a, 4'd0});
    exp_w = mreg[a];
    while (idx < 4 && cyc < 100) begin
      chk("read_valid", 32'(out_valid), 32'd1);
      chk("read_data", 32'(out_data), 32'(byte_of(exp_w, idx)));
      r = use_pat ? pat[p % 7] : 1'($urandom % 2);
      p++;
      out_ready = r;
      if (r) idx++;
      @(negedge clock);
      out_ready = 1'b0;
      cyc++;
    end
    chk("read_done_busy", 32'(busy), 32'd0);
    chk("read_done_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic alu_run(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] d, input bit respond, input logic [31:0] res,
                         input int lat);
    bit hs = 0;
    int cyc = 0;
    send_cmd({op, a, b, d});
    while (!hs && cyc < 50) begin
      chk("alu_valid", 32'(alu_op_valid), 32'd1);
      chk("alu_a", alu_a, mreg[a]);
      chk("alu_b", alu_b, mreg[b]);
      chk("alu_op", 32'(alu_op), 32'(op));
      if ($urandom % 2 == 0 || cyc > 4) begin
        alu_op_ready = 1'b1;
        hs = 1;
      end
      @(negedge clock);
      alu_op_ready = 1'b0;
      cyc++;
    end
    if (!hs) chk("alu_hs_timeout", 32'd0, 32'd1);
    if (respond) begin
      repeat (lat - 1) @(negedge clock);
      chk("wait_busy", 32'(busy), 32'd1);
      alu_result_valid = 1'b1;
      alu_result       = res;
      @(negedge clock);
      alu_result_valid = 1'b0;
      mreg[d] = res;
      chk("wb_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reset = 1'b1; cs_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; alu_op_ready = 1'b0;
    alu_result_valid = 1'b0; alu_result = '0;
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_valid", 32'(alu_op_valid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);

    // Directed: load then read back, then 1.0 + 2.0.
    load(2'd2, 32'h3F800000, 4);
    read(2'd2, 1'b0);
    load(2'd0, 32'h3F800000, 4);
    load(2'd1, 32'h40000000, 4);
    alu_run(2'd1, 2'd0, 2'd1, 2'd2, 1'b1, 32'h40400000, 3);
    read(2'd2, 1'b0);

    // Aborted load leaves the register alone; stalled readback pattern.
    load(2'd1, $urandom, 2);
    read(2'd1, 1'b1);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] op, a, b, d;
      op = 2'($urandom); a = 2'($urandom); b = 2'($urandom); d = 2'($urandom);
      case (op)
        2'd0: load(d, $urandom, ($urandom % 4 == 0) ? int'($urandom % 4) : 4);
        2'd3: read(a, 1'($urandom % 2));
        default: alu_run(op, a, b, d, 1'b1, $urandom, int'($urandom_range(1, 6)));
      endcase
    end
    for (int i = 0; i < 4; i++) read(2'(i), 1'b0);

    // ALU never answers.
    alu_run(2'd2, 2'd3, 2'd0, 2'd1, 1'b0, 32'd0, 1);
`ifdef FPU_SEQ_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      chk("to_error_low", 32'(error), 32'd0);
      chk("to_busy_high", 32'(busy), 32'd1);
      @(negedge clock);
    end
    chk("to_error_set", 32'(error), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    read(2'd1, 1'b0);
    chk("to_error_sticky", 32'(error), 32'd1);
    alu_run(2'd1, 2'd0, 2'd1, 2'd3, 1'b0, 32'd0, 1);
`else
    repeat (40) @(negedge clock);
    chk("hang_busy", 32'(busy), 32'd1);
    chk("hang_error", 32'(error), 32'd0);
`endif

    // Reset while in WAIT, then a late result strobe.
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    alu_result_valid = 1'b1;
    alu_result       = $urandom | 32'h1;
    @(negedge clock);
    alu_result_valid = 1'b0;
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_error", 32'(error), 32'd0);
    chk("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) read(2'(i), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
    $finish;
  end
endmodule
